ex_mem_pipe_stage: RTL and testbench
====================================

# ex_mem_pipe_stage

Parametrised EX→MEM pipeline register with a valid/ready handshake, synchronous flush, an optional two-entry skid buffer and saturating stall/bubble performance counters. It sits between the execute and memory stages and carries the ALU result, store data, destination register and PC+4. It replaces the plain always-load stage register so that MEM-side back-pressure and branch/exception flushes are handled inside the stage.

## Interface
Parameters:
- DATA_W, 32, width of alu_result, write_data and pc_plus4
- RD_W, 5, width of the destination register index
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held and incoming beats
- in_valid  in  1  EX-side beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_alu_result, in_write_data, in_pc_plus4  in  DATA_W each  EX payload
- in_rd  in  RD_W  EX destination register
- out_valid  out  1  MEM-side beat valid
- out_ready  in  1  MEM stage accepts the beat
- out_alu_result, out_write_data, out_pc_plus4  out  DATA_W each  MEM payload
- out_rd  out  RD_W  MEM destination register
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0

## Operation
- Input fire = in_valid && in_ready. Output fire = out_valid && out_ready.
- Main register (M) drives the out_* ports. The skid register (S) exists only when SKID=1.
- SKID=0: in_ready = !out_valid || out_ready. On input fire, M loads the payload and out_valid=1. On output fire without input fire, out_valid=0.
- SKID=1: in_ready = !s_valid, taken from a flop only.
  - Input fire while M is empty or draining: load M.
  - Input fire while M is full and not draining: load S, so s_valid=1.
  - Output fire while s_valid=1: S moves to M and s_valid=0.
  - Input fire and S→M cannot happen in the same cycle, because in_ready=0 whenever s_valid=1.
- Flush has the highest priority over every other event:
  - Next cycle out_valid=0 and s_valid=0.
  - M and S payloads are cleared to 0, so out_rd=0.
  - A beat presented in the same cycle is consumed (if in_ready=1) and discarded.
  - Counters are not affected.
- When out_valid drops without a flush, the payload holds its last value. Consumers must qualify every field with out_valid.
- Counters saturate at all-ones and are cleared only by reset.
  - stall_cnt increments in every cycle with out_valid && !out_ready.
  - bubble_cnt increments in every cycle with !out_valid, including the cycle during and after a flush.

## Timing
- Reset values: out_valid=0, all out_* payload=0, s_valid=0, stall_cnt=0, bubble_cnt=0.
- in_ready reads 1 during and after reset.
- Latency: 1 cycle from input fire to out_valid. Throughput: 1 beat per cycle when out_ready=1.
- SKID=1 has no combinational path from out_ready to in_ready. SKID=0 does.
- Order is strict FIFO: M before S. No beat is lost or duplicated except through flush.
- Reset asserted mid-transfer clears all state immediately, with no clock edge required.
- Counters are updated on the same edge as the state they sample, so the counter value lags its condition by one cycle.

## Structure
- Shared package pipe_pkg holds:
  - Default constants PIPE_DATA_W=32, PIPE_RD_W=5, PIPE_CNT_W=16.
  - Payload struct typedef ex_mem_payload_t (alu_result, write_data, rd, pc_plus4), used for both M and S.
- Sub-module pipe_sat_counter (parameter W; inputs clk, reset, inc; output count), instantiated twice.
- The S register and its control are generated only when SKID=1.

## Test plan
- Reset/basic transfer: assert reset, then send one beat with alu_result=0x0000_1234, rd=5, keeping out_ready=1.
  - Required: out_valid=1 one cycle later with matching payload, then 0.
  - Required: bubble_cnt counts every idle cycle after reset.
- Back-pressure (SKID=1): hold out_ready=0 while 3 beats (rd=1,2,3) are offered back-to-back.
  - Required: beats 1 and 2 are accepted; in_ready=0 from the cycle after beat 2 is accepted.
  - Required: stall_cnt increments each stalled cycle.
  - Required: on releasing out_ready, the output order is 1, 2, 3 with no loss.
- Flush with full buffers: M and S both hold beats and a new beat is offered; assert flush for one cycle.
  - Required: next cycle out_valid=0, out_rd=0, in_ready=1.
  - Required: none of the three beats ever appears at the output.
- SKID=0 streaming: 8 consecutive beats with out_ready toggling every cycle.
  - Required: in_ready equals !out_valid || out_ready combinationally.
  - Required: all 8 beats come out in order.
- Counter saturation (CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles.
  - Required: stall_cnt stops at 15 and does not wrap.
- Async reset mid-stall: assert reset between clock edges while M and S are full.
  - Required: out_valid, all payload fields and both counters are 0 immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and the EX->MEM payload record
package pipe_pkg;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_RD_W = 5;
  localparam int PIPE_CNT_W = 16;
  typedef struct packed {
    logic [PIPE_DATA_W-1:0] alu_result;
    logic [PIPE_DATA_W-1:0] write_data;
    logic [PIPE_RD_W-1:0]   rd;
    logic [PIPE_DATA_W-1:0] pc_plus4;
  } ex_mem_payload_t;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: event counter that sticks at all-ones, cleared only by reset
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  // count qualifying cycles, holding once the top value is reached
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (inc && count != {W{1'b1}}) count <= count + 1'b1;
endmodule

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage: EX->MEM register slice with handshake, flush, optional skid and perf counters
module ex_mem_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int RD_W   = PIPE_RD_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_write_data,
  output logic [DATA_W-1:0] out_pc_plus4,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  ex_mem_payload_t w_in, r_m, w_s;
  logic r_m_valid, w_s_valid, w_in_fire, w_out_fire, w_stall_inc, w_bubble_inc;
  assign w_in = '{alu_result: PIPE_DATA_W'(in_alu_result), write_data: PIPE_DATA_W'(in_write_data),
                  rd: PIPE_RD_W'(in_rd), pc_plus4: PIPE_DATA_W'(in_pc_plus4)};
  assign w_in_fire = in_valid && in_ready;
  assign w_out_fire = r_m_valid && out_ready;
  generate
    if (SKID != 0) begin : g_skid
      ex_mem_payload_t r_s;
      logic r_s_valid;
      // skid slot catches a beat accepted while M is stuck, and drains into M first
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_s_valid <= 1'b0;
          r_s <= '0;
        end else if (flush) begin
          r_s_valid <= 1'b0;
          r_s <= '0;
        end else if (r_s_valid && w_out_fire) r_s_valid <= 1'b0;
        else if (w_in_fire && r_m_valid && !out_ready) begin
          r_s_valid <= 1'b1;
          r_s <= w_in;
        end
      assign w_s_valid = r_s_valid;
      assign w_s = r_s;
      assign in_ready = !r_s_valid;
    end else begin : g_noskid
      assign w_s_valid = 1'b0;
      assign w_s = '0;
      assign in_ready = !r_m_valid || out_ready;
    end
  endgenerate
  // main register: refill from skid first, else from EX when empty or draining
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_m <= '0;
    end else if (w_s_valid && w_out_fire) r_m <= w_s;
    else if (w_in_fire && (!r_m_valid || out_ready)) begin
      r_m_valid <= 1'b1;
      r_m <= w_in;
    end else if (w_out_fire) r_m_valid <= 1'b0;
  assign out_valid = r_m_valid;
  assign out_alu_result = DATA_W'(r_m.alu_result);
  assign out_write_data = DATA_W'(r_m.write_data);
  assign out_pc_plus4 = DATA_W'(r_m.pc_plus4);
  assign out_rd = RD_W'(r_m.rd);
  assign w_stall_inc = r_m_valid && !out_ready;
  assign w_bubble_inc = !r_m_valid;
  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(w_stall_inc), .count(stall_cnt));
  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (.clk(clk), .reset(reset), .inc(w_bubble_inc), .count(bubble_cnt));
endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// tb_ex_mem_pipe_stage: directed checks of a skid instance (CNT_W=16) and a plain instance (CNT_W=4)
module tb_ex_mem_pipe_stage;
  logic clk = 1'b0;
  logic reset, a_flush, b_flush;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_alu, a_wd, a_pc, a_out_alu, a_out_wd, a_out_pc;
  logic [4:0] a_rd, a_out_rd;
  logic [15:0] a_stall, a_bubble;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_alu, b_wd, b_pc, b_out_alu, b_out_wd, b_out_pc;
  logic [4:0] b_rd, b_out_rd;
  logic [3:0] b_stall, b_bubble;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_stage #(.DATA_W(32), .RD_W(5), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_alu_result(a_alu), .in_write_data(a_wd), .in_pc_plus4(a_pc), .in_rd(a_rd),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_alu_result(a_out_alu),
    .out_write_data(a_out_wd), .out_pc_plus4(a_out_pc), .out_rd(a_out_rd),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble));

  ex_mem_pipe_stage #(.DATA_W(32), .RD_W(5), .SKID(0), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_alu_result(b_alu), .in_write_data(b_wd), .in_pc_plus4(b_pc), .in_rd(b_rd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_alu_result(b_out_alu),
    .out_write_data(b_out_wd), .out_pc_plus4(b_out_pc), .out_rd(b_out_rd),
    .stall_cnt(b_stall), .bubble_cnt(b_bubble));

  task automatic idle_inputs();
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_alu = 0; a_wd = 0; a_pc = 0; a_rd = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_alu = 0; b_wd = 0; b_pc = 0; b_rd = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    @(negedge clk);
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
    total++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b/%b want=1/1", a_in_ready, b_in_ready); end
    total++; if (a_out_rd !== 5'd0 || a_out_alu !== 32'd0) begin bad++; $display("FAIL reset_payload got rd=%0d alu=%h want 0", a_out_rd, a_out_alu); end
    total++; if (a_stall !== 16'd0 || a_bubble !== 16'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", a_stall, a_bubble); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_basic();
    repeat (3) @(negedge clk);
    total++; if (a_bubble !== 16'd3) begin bad++; $display("FAIL basic_idle_bubble got=%0d want=3", a_bubble); end
    a_in_valid = 1; a_alu = 32'h0000_1234; a_wd = 32'hdead_beef; a_pc = 32'h0000_0104; a_rd = 5'd5; a_out_ready = 1;
    @(negedge clk);
    a_in_valid = 0;
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", a_out_valid); end
    total++; if (a_out_alu !== 32'h0000_1234 || a_out_rd !== 5'd5) begin bad++; $display("FAIL basic_payload got alu=%h rd=%0d want 1234/5", a_out_alu, a_out_rd); end
    total++; if (a_out_wd !== 32'hdead_beef || a_out_pc !== 32'h0000_0104) begin bad++; $display("FAIL basic_wd_pc got=%h/%h want deadbeef/00000104", a_out_wd, a_out_pc); end
    total++; if (a_bubble !== 16'd4) begin bad++; $display("FAIL basic_bubble_load got=%0d want=4", a_bubble); end
    @(negedge clk);
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%b want=0", a_out_valid); end
    total++; if (a_out_alu !== 32'h0000_1234) begin bad++; $display("FAIL basic_hold got=%h want=00001234", a_out_alu); end
    total++; if (a_bubble !== 16'd4) begin bad++; $display("FAIL basic_bubble_busy got=%0d want=4", a_bubble); end
    @(negedge clk);
    total++; if (a_bubble !== 16'd5) begin bad++; $display("FAIL basic_bubble_after got=%0d want=5", a_bubble); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_out_ready = 0; a_in_valid = 1; a_rd = 5'd1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_beat1 got=%b want=1", a_in_ready); end
    @(negedge clk);
    total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_out_rd !== 5'd1) begin bad++; $display("FAIL bp_after_beat1 got ready=%b valid=%b rd=%0d want 1/1/1", a_in_ready, a_out_valid, a_out_rd); end
    a_rd = 5'd2;
    @(negedge clk);
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", a_in_ready); end
    total++; if (a_stall !== 16'd1) begin bad++; $display("FAIL bp_stall1 got=%0d want=1", a_stall); end
    a_rd = 5'd3;
    @(negedge clk);
    total++; if (a_in_ready !== 1'b0 || a_out_rd !== 5'd1) begin bad++; $display("FAIL bp_hold got ready=%b rd=%0d want 0/1", a_in_ready, a_out_rd); end
    total++; if (a_stall !== 16'd2) begin bad++; $display("FAIL bp_stall2 got=%0d want=2", a_stall); end
    a_out_ready = 1;
    @(negedge clk);
    total++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd2 || a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_second got valid=%b rd=%0d ready=%b want 1/2/1", a_out_valid, a_out_rd, a_in_ready); end
    total++; if (a_stall !== 16'd2) begin bad++; $display("FAIL bp_stall_release got=%0d want=2", a_stall); end
    @(negedge clk);
    a_in_valid = 0;
    total++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd3) begin bad++; $display("FAIL bp_third got valid=%b rd=%0d want 1/3", a_out_valid, a_out_rd); end
    @(negedge clk);
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", a_out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    a_out_ready = 0; a_in_valid = 1; a_rd = 5'd7; a_alu = 32'h77;
    @(negedge clk);
    a_rd = 5'd8; a_alu = 32'h88;
    @(negedge clk);
    a_rd = 5'd9; a_alu = 32'h99; a_flush = 1;
    #1;
    total++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd7 || a_in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre got valid=%b rd=%0d ready=%b want 1/7/0", a_out_valid, a_out_rd, a_in_ready); end
    @(negedge clk);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    total++; if (a_out_valid !== 1'b0 || a_out_rd !== 5'd0 || a_out_alu !== 32'd0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL flush_post got valid=%b rd=%0d alu=%h ready=%b want 0/0/0/1", a_out_valid, a_out_rd, a_out_alu, a_in_ready); end
    total++; if (a_stall !== 16'd2 || a_bubble !== 16'd1) begin bad++; $display("FAIL flush_counters got stall=%0d bubble=%0d want 2/1", a_stall, a_bubble); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak cycle=%0d rd=%0d want no beat", i, a_out_rd); end
    end
    total++; if (a_bubble !== 16'd5) begin bad++; $display("FAIL flush_bubble got=%0d want=5", a_bubble); end
    a_in_valid = 1; a_rd = 5'd10; a_flush = 1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL flush_same_ready got=%b want=1", a_in_ready); end
    @(negedge clk);
    a_in_valid = 0; a_flush = 0;
    total++; if (a_out_valid !== 1'b0 || a_out_rd !== 5'd0) begin bad++; $display("FAIL flush_same_beat got valid=%b rd=%0d want 0/0", a_out_valid, a_out_rd); end
  endtask

  task automatic test_skid0_stream();
    int n_in = 0;
    int n_out = 0;
    do_reset();
    for (int c = 0; c < 40 && n_out < 8; c++) begin
      b_out_ready = c[0];
      b_in_valid = (n_in < 8);
      b_rd = 5'(n_in + 1);
      b_alu = 32'h100 + 32'(n_in + 1);
      #1;
      total++; if (b_in_ready !== (!b_out_valid || b_out_ready)) begin bad++; $display("FAIL s0_ready cycle=%0d got=%b valid=%b oready=%b", c, b_in_ready, b_out_valid, b_out_ready); end
      if (b_out_valid && b_out_ready) begin
        total++; if (b_out_rd !== 5'(n_out + 1) || b_out_alu !== 32'h100 + 32'(n_out + 1)) begin bad++; $display("FAIL s0_order got rd=%0d alu=%h want rd=%0d", b_out_rd, b_out_alu, n_out + 1); end
        n_out++;
      end
      if (b_in_valid && b_in_ready) n_in++;
      @(negedge clk);
    end
    b_in_valid = 0;
    total++; if (n_out != 8) begin bad++; $display("FAIL s0_count got=%0d want=8", n_out); end
  endtask

  task automatic test_saturation();
    do_reset();
    b_in_valid = 1; b_rd = 5'd3; b_out_ready = 0;
    @(negedge clk);
    b_in_valid = 0;
    total++; if (b_out_valid !== 1'b1 || b_stall !== 4'd0) begin bad++; $display("FAIL sat_start got valid=%b stall=%0d want 1/0", b_out_valid, b_stall); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      total++; if (b_stall !== 4'((k < 15) ? k : 15)) begin bad++; $display("FAIL sat_stall k=%0d got=%0d want=%0d", k, b_stall, (k < 15) ? k : 15); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    a_out_ready = 0; a_in_valid = 1; a_rd = 5'd4; a_alu = 32'h44; a_wd = 32'h55; a_pc = 32'h66;
    @(negedge clk);
    a_rd = 5'd6;
    @(negedge clk);
    a_in_valid = 0;
    @(negedge clk);
    total++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_stall === 16'd0) begin bad++; $display("FAIL ar_pre got valid=%b ready=%b stall=%0d want full", a_out_valid, a_in_ready, a_stall); end
    #2 reset = 1;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_out_rd !== 5'd0 || a_out_alu !== 32'd0 || a_out_wd !== 32'd0 || a_out_pc !== 32'd0) begin bad++; $display("FAIL ar_payload got valid=%b rd=%0d alu=%h wd=%h pc=%h want all 0", a_out_valid, a_out_rd, a_out_alu, a_out_wd, a_out_pc); end
    total++; if (a_stall !== 16'd0 || a_bubble !== 16'd0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL ar_state got stall=%0d bubble=%0d ready=%b want 0/0/1", a_stall, a_bubble, a_in_ready); end
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_skid0_stream();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
